// File: rtl/sdram_rom_port.sv
// sdram_rom_port: serialises ROM download writes and two 32-bit ROM readers onto one SDRAM controller port
module sdram_rom_port #(
  parameter int CAP_CYCLE  = 7,
  parameter int LAST_CYCLE = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  sm_cycle,
  input  logic [15:0] sd_data_in,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  input  logic        c0_req,
  input  logic [24:0] c0_addr,
  output logic        c0_ack,
  output logic [31:0] c0_data,
  input  logic        c1_req,
  input  logic [24:0] c1_addr,
  output logic        c1_ack,
  output logic [31:0] c1_data,
  output logic        sdr_we,
  output logic        sdr_rd,
  output logic [24:0] sdr_addr,
  output logic [7:0]  sdr_di
);
  typedef enum logic [1:0] {SYNC, IDLE, RUN} state_t;
  state_t      r_state;
  logic [1:0]  r_gnt;
  logic        r_rr;
  logic [31:0] r_cap;
  logic        w_c1;
  logic [24:0] w_raddr;
  assign w_c1    = c1_req & (~c0_req | r_rr);
  assign w_raddr = w_c1 ? c1_addr : c0_addr;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= SYNC;
      r_gnt    <= 2'd0;
      r_rr     <= 1'b0;
      r_cap    <= 32'd0;
      sdr_we   <= 1'b0;
      sdr_rd   <= 1'b0;
      sdr_addr <= 25'd0;
      sdr_di   <= 8'd0;
      dl_ready <= 1'b0;
      c0_ack   <= 1'b0;
      c1_ack   <= 1'b0;
      c0_data  <= 32'd0;
      c1_data  <= 32'd0;
    end else begin
      dl_ready <= 1'b0;
      c0_ack   <= 1'b0;
      c1_ack   <= 1'b0;
      case (r_state)
        SYNC: if (sm_cycle == 5'd0) r_state <= IDLE;
        IDLE: if (sm_cycle == 5'd0 && (dl_wr | c0_req | c1_req)) begin
          r_state <= RUN;
          if (dl_wr) begin
            sdr_we   <= 1'b1;
            sdr_rd   <= 1'b0;
            sdr_addr <= dl_addr;
            sdr_di   <= dl_data;
            r_gnt    <= 2'd0;
          end else begin
            sdr_we   <= 1'b0;
            sdr_rd   <= 1'b1;
            sdr_addr <= w_raddr & ~25'd3;
            r_gnt    <= w_c1 ? 2'd2 : 2'd1;
            r_rr     <= ~w_c1;
          end
        end
        RUN: begin
          if (sm_cycle == 5'(CAP_CYCLE)) r_cap[15:0] <= sd_data_in;
          if (sm_cycle == 5'(CAP_CYCLE + 1)) r_cap[31:16] <= sd_data_in;
          if (sm_cycle == 5'(LAST_CYCLE)) begin
            r_state  <= IDLE;
            sdr_we   <= 1'b0;
            sdr_rd   <= 1'b0;
            dl_ready <= r_gnt == 2'd0;
            c0_ack   <= r_gnt == 2'd1;
            c1_ack   <= r_gnt == 2'd2;
            if (r_gnt == 2'd1) c0_data <= r_cap;
            if (r_gnt == 2'd2) c1_data <= r_cap;
          end
        end
        default: r_state <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_rom_port.sv
// tb_sdram_rom_port: directed table and corner sequences against a behavioural controller counter
module tb_sdram_rom_port;
  logic        clk = 0, reset = 1;
  logic [4:0]  sm_cycle = 0;
  logic [15:0] sd_data_in, w0 = 0, w1 = 0;
  logic        dl_wr = 0, c0_req = 0, c1_req = 0;
  logic [24:0] dl_addr = 0, c0_addr = 0, c1_addr = 0;
  logic [7:0]  dl_data = 0;
  logic        dl_ready, c0_ack, c1_ack, sdr_we, sdr_rd;
  logic [31:0] c0_data, c1_data, exp_c0 = 0, exp_c1 = 0;
  logic [24:0] sdr_addr;
  logic [7:0]  sdr_di;
  int          n_chk = 0, n_pass = 0, cyc = 0;

  sdram_rom_port dut (
    .clk(clk), .reset(reset), .sm_cycle(sm_cycle), .sd_data_in(sd_data_in),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ready(dl_ready),
    .c0_req(c0_req), .c0_addr(c0_addr), .c0_ack(c0_ack), .c0_data(c0_data),
    .c1_req(c1_req), .c1_addr(c1_addr), .c1_ack(c1_ack), .c1_data(c1_data),
    .sdr_we(sdr_we), .sdr_rd(sdr_rd), .sdr_addr(sdr_addr), .sdr_di(sdr_di)
  );

  always #5 clk = ~clk;

  // Controller: leaves state 0 only when it sees a request, then runs 1..15 and wraps
  always @(posedge clk) begin
    cyc <= cyc + 1;
    sm_cycle <= sm_cycle == 5'd0 ? ((sdr_we | sdr_rd) ? 5'd1 : 5'd0)
              : sm_cycle == 5'd15 ? 5'd0 : sm_cycle + 5'd1;
  end
  assign sd_data_in = sm_cycle == 5'd7 ? w0 : sm_cycle == 5'd8 ? w1 : 16'hDEAD;

  typedef struct {
    int          kind;
    logic [24:0] addr;
    logic [7:0]  d;
    logic [15:0] w0, w1;
    logic [24:0] ea;
    logic [31:0] ed;
  } vec_t;
  vec_t v[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t x, input int idx);
    int act = 0, bad = 0, lat = 0;
    logic got = 0;
    @(negedge clk);
    w0 = x.w0; w1 = x.w1;
    if (x.kind == 0) begin dl_addr = x.addr; dl_data = x.d; dl_wr = 1; end
    if (x.kind == 1) begin c0_addr = x.addr; c0_req = 1; end
    if (x.kind == 2) begin c1_addr = x.addr; c1_req = 1; end
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (sdr_we | sdr_rd) begin
        act++;
        if ({sdr_we, sdr_rd} != (x.kind == 0 ? 2'b10 : 2'b01) || sdr_addr != x.ea ||
            (x.kind == 0 && sdr_di != x.d)) bad++;
      end
      got = x.kind == 0 ? dl_ready : x.kind == 1 ? c0_ack : c1_ack;
      if (got) lat = n;
    end
    dl_wr = 0; c0_req = 0; c1_req = 0;
    if (x.kind == 1) exp_c0 = x.ed;
    if (x.kind == 2) exp_c1 = x.ed;
    check($sformatf("v%0d_latency", idx), lat, 17);
    check($sformatf("v%0d_active", idx), act, 16);
    check($sformatf("v%0d_hold", idx), bad, 0);
    check($sformatf("v%0d_clear", idx), {sdr_we, sdr_rd, sm_cycle}, 0);
    check($sformatf("v%0d_c0_data", idx), c0_data, exp_c0);
    check($sformatf("v%0d_c1_data", idx), c1_data, exp_c1);
    @(negedge clk);
    check($sformatf("v%0d_ack_pulse", idx), {dl_ready, c0_ack, c1_ack}, 0);
  endtask

  initial begin
    int k, early, lat, rd0, n_end;
    int ord[5];
    int t[4];
    logic [24:0] ba[4];
    logic [15:0] bw[4];
    v[0] = '{0, 25'h0001235, 8'hA5, 16'h0000, 16'h0000, 25'h0001235, 32'h0};
    v[1] = '{1, 25'h0000403, 8'h00, 16'h1111, 16'h2222, 25'h0000400, 32'h22221111};
    v[2] = '{2, 25'h1FFFFFF, 8'h00, 16'hBEEF, 16'hCAFE, 25'h1FFFFFC, 32'hCAFEBEEF};
    v[3] = '{0, 25'h1FFFFFF, 8'h5A, 16'h0000, 16'h0000, 25'h1FFFFFF, 32'h0};
    v[4] = '{1, 25'h0ABCDE2, 8'h00, 16'h0123, 16'h4567, 25'h0ABCDE0, 32'h45670123};
    ba = '{25'h0000010, 25'h0000021, 25'h0000032, 25'h0000043};
    bw = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

    repeat (3) @(negedge clk);
    check("rst_ctl", {sdr_we, sdr_rd, dl_ready, c0_ack, c1_ack}, 0);
    check("rst_addr", sdr_addr, 0);
    check("rst_di", sdr_di, 0);
    check("rst_c0_data", c0_data, 0);
    check("rst_c1_data", c1_data, 0);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(v[i], i);

    // reset in the middle of a ch0 read
    @(negedge clk);
    c0_addr = 25'h0000808; c0_req = 1; w0 = 16'h7777; w1 = 16'h8888;
    for (int n = 0; n < 40 && sm_cycle != 5'd6; n++) @(negedge clk);
    check("mid_reach6", {sdr_rd, sm_cycle}, {1'b1, 5'd6});
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("mid_rd_clear", sdr_rd, 0);
    check("mid_no_ack", c0_ack, 0);
    check("mid_data_zero", c0_data, 0);
    early = 0;
    for (int n = 0; n < 40 && sm_cycle != 5'd0; n++) begin
      @(negedge clk);
      if (sdr_rd | sdr_we | c0_ack) early++;
    end
    check("mid_wrap", sm_cycle, 0);
    check("mid_no_early_grant", early, 0);
    lat = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(negedge clk);
      if (c0_ack) lat = n;
    end
    c0_req = 0;
    check("mid_regrant_latency", lat, 18);
    check("mid_new_data", c0_data, 32'h88887777);

    // three-way contention straight after reset: write, ch0, ch1, then ch0/ch1 alternate
    do_reset();
    dl_addr = 25'h0000777; dl_data = 8'h3C; c0_addr = 25'h0000100; c1_addr = 25'h0000200;
    dl_wr = 1; c0_req = 1; c1_req = 1;
    k = 0; n_end = 0;
    for (int n = 1; n <= 200 && k < 5; n++) begin
      @(negedge clk);
      if (dl_ready) begin ord[k] = 0; k++; dl_wr = 0; end
      if (c0_ack) begin ord[k] = 1; k++; end
      if (c1_ack) begin ord[k] = 2; k++; end
      n_end = n;
    end
    c0_req = 0; c1_req = 0; dl_wr = 0;
    check("cont_acks", k, 5);
    check("cont_cycles", n_end, 85);
    check("cont_ord0", ord[0], 0);
    check("cont_ord1", ord[1], 1);
    check("cont_ord2", ord[2], 2);
    check("cont_ord3", ord[3], 1);
    check("cont_ord4", ord[4], 2);

    // back-to-back ch1 reads, address advanced right after each ack
    @(negedge clk);
    c1_addr = ba[0]; w0 = bw[0]; w1 = ~bw[0]; c1_req = 1;
    k = 0; rd0 = 0;
    for (int n = 0; n < 200 && k < 4; n++) begin
      @(negedge clk);
      if (sdr_rd && sm_cycle == 5'd0) rd0++;
      if (c1_ack) begin
        t[k] = cyc;
        check($sformatf("b2b_data%0d", k), c1_data, {~bw[k], bw[k]});
        k++;
        if (k < 4) begin c1_addr = ba[k]; w0 = bw[k]; w1 = ~bw[k]; end
        else c1_req = 0;
      end
    end
    check("b2b_acks", k, 4);
    for (int i = 1; i < 4; i++) check($sformatf("b2b_gap%0d", i), t[i] - t[i-1], 17);
    check("b2b_rd_at_0", rd0, 4);
    @(negedge clk);
    check("b2b_idle", {sdr_we, sdr_rd, c1_ack}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
